// File: rtl/i2c_seq_ctrl.sv
// i2c_seq_ctrl: Wishbone master that turns single-beat register requests
// into full I2C register write/read transactions on an 8-bit I2C master core.
// Ports: wb_clk_i/rst_i (async, active-low); req_* host request (valid/ready);
// rsp_* one-cycle response (rdata, err 0=OK 1=NACK 2=AL 3=timeout);
// m_* single-beat Wishbone master to the core; m_inta_i core interrupt.
// Build option: I2C_SEQ_IRQ_EN waits on m_inta_i instead of polling sr.
module i2c_seq_ctrl #(
  parameter logic [15:0] PRESCALE = 16'd99,
  parameter logic [19:0] TIMEOUT  = 20'd1000000
) (
  input  logic       wb_clk_i,
  input  logic       rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       m_cyc_o,
  output logic       m_stb_o,
  output logic       m_we_o,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  input  logic       m_ack_i,
  input  logic       m_inta_i
);

  typedef enum logic [3:0] {
    INIT0, INIT1, INIT2, IDLE, WR_TXR, WR_CR, POLL, EVAL,
    RD_RXR, STOP_CR, STOP_POLL, FINAL_IACK, RESP
  } state_t;

  state_t      state;
  logic [1:0]  phase;
  logic        rw;
  logic [6:0]  dev;
  logic [7:0]  rg;
  logic [7:0]  wd;
  logic [7:0]  rdata;
  logic [1:0]  err;
  logic        al_q;
  logic        nack_q;
  logic        to_q;
  logic [19:0] wcnt;

  logic        ack;
  logic        poll_go;
  logic        poll_hit;
  logic [7:0]  ctr_v;

  assign ack = m_cyc_o & m_ack_i;

`ifdef I2C_SEQ_IRQ_EN
  // sr is read only once the core interrupts; that read is the result.
  assign ctr_v    = 8'hC0;
  assign poll_go  = m_inta_i;
  assign poll_hit = 1'b1;
`else
  logic unused_inta;
  assign unused_inta = m_inta_i;
  assign ctr_v    = 8'h80;
  assign poll_go  = 1'b1;
  assign poll_hit = m_dat_i[0];
`endif

  logic [7:0] txr_v;
  logic [7:0] cr_v;

  always_comb begin
    txr_v = 8'h00;
    cr_v  = 8'h69;
    case (phase)
      2'd0: begin
        txr_v = {dev, 1'b0};
        cr_v  = 8'h91;
      end
      2'd1: begin
        txr_v = rg;
        cr_v  = 8'h11;
      end
      2'd2: begin
        txr_v = rw ? {dev, 1'b1} : wd;
        cr_v  = rw ? 8'h91 : 8'h51;
      end
      default: ;
    endcase
  end

  logic       acc_req;
  logic       acc_we;
  logic [2:0] acc_adr;
  logic [7:0] acc_dat;

  always_comb begin
    acc_req = 1'b0;
    acc_we  = 1'b1;
    acc_adr = 3'd0;
    acc_dat = 8'h00;
    unique case (state)
      INIT0: begin
        acc_req = 1'b1;
        acc_dat = PRESCALE[7:0];
      end
      INIT1: begin
        acc_req = 1'b1;
        acc_adr = 3'd1;
        acc_dat = PRESCALE[15:8];
      end
      INIT2: begin
        acc_req = 1'b1;
        acc_adr = 3'd2;
        acc_dat = ctr_v;
      end
      WR_TXR: begin
        acc_req = 1'b1;
        acc_adr = 3'd3;
        acc_dat = txr_v;
      end
      WR_CR: begin
        acc_req = 1'b1;
        acc_adr = 3'd4;
        acc_dat = cr_v;
      end
      POLL, STOP_POLL: begin
        acc_req = poll_go;
        acc_we  = 1'b0;
        acc_adr = 3'd4;
      end
      RD_RXR: begin
        acc_req = 1'b1;
        acc_we  = 1'b0;
        acc_adr = 3'd3;
      end
      STOP_CR: begin
        acc_req = 1'b1;
        acc_adr = 3'd4;
        acc_dat = to_q ? 8'h40 : 8'h41;
      end
      FINAL_IACK: begin
        acc_req = 1'b1;
        acc_adr = 3'd4;
        acc_dat = 8'h01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= INIT0;
      phase     <= 2'd0;
      rw        <= 1'b0;
      dev       <= 7'd0;
      rg        <= 8'h00;
      wd        <= 8'h00;
      rdata     <= 8'h00;
      err       <= 2'd0;
      al_q      <= 1'b0;
      nack_q    <= 1'b0;
      to_q      <= 1'b0;
      wcnt      <= 20'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 2'd0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_adr_o   <= 3'd0;
      m_dat_o   <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 2'd0;
      if (ack) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
        m_we_o  <= 1'b0;
        m_adr_o <= 3'd0;
        m_dat_o <= 8'h00;
      end else if (!m_cyc_o && acc_req) begin
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        m_we_o  <= acc_we;
        m_adr_o <= acc_adr;
        m_dat_o <= acc_dat;
      end
      unique case (state)
        INIT0: if (ack) state <= INIT1;
        INIT1: if (ack) state <= INIT2;
        INIT2: begin
          if (ack) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            rw        <= req_rw;
            dev       <= req_dev;
            rg        <= req_reg;
            wd        <= req_wdata;
            rdata     <= 8'h00;
            err       <= 2'd0;
            phase     <= 2'd0;
            state     <= WR_TXR;
          end
        end
        WR_TXR: if (ack) state <= WR_CR;
        WR_CR: begin
          if (ack) begin
            wcnt  <= 20'd0;
            state <= POLL;
          end
        end
        POLL, STOP_POLL: begin
          if (wcnt == TIMEOUT) begin
            // abandon any in-flight sr read
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= 3'd0;
            m_dat_o <= 8'h00;
            to_q    <= 1'b1;
            err     <= 2'd3;
            state   <= STOP_CR;
          end else begin
            if (wcnt != '1) wcnt <= wcnt + 20'd1;
            if (ack && poll_hit) begin
              al_q   <= m_dat_i[5];
              nack_q <= m_dat_i[7];
              state  <= (state == POLL) ? EVAL : FINAL_IACK;
            end
          end
        end
        EVAL: begin
          if (al_q) begin
            err   <= 2'd2;
            state <= FINAL_IACK;
          end else if (nack_q && !(rw && phase == 2'd3)) begin
            // the read byte is NACKed by us, so rxack is meaningless there
            err   <= 2'd1;
            state <= STOP_CR;
          end else if (phase == 2'd3) begin
            state <= RD_RXR;
          end else if (phase == 2'd2 && !rw) begin
            state <= FINAL_IACK;
          end else begin
            phase <= phase + 2'd1;
            state <= (phase == 2'd2) ? WR_CR : WR_TXR;
          end
        end
        RD_RXR: begin
          if (ack) begin
            rdata <= m_dat_i;
            state <= FINAL_IACK;
          end
        end
        STOP_CR: begin
          if (ack) begin
            wcnt  <= 20'd0;
            state <= to_q ? RESP : STOP_POLL;
          end
        end
        FINAL_IACK: if (ack) state <= RESP;
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err == 2'd0) ? rdata : 8'h00;
          to_q      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= INIT0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// tb_i2c_seq_ctrl: random register transactions against a behavioural
// I2C core model; expected bus logs come from a transaction-level model.
module tb_i2c_seq_ctrl;
  localparam logic [19:0] TO = 20'd60;
`ifdef I2C_SEQ_IRQ_EN
  localparam logic [7:0] CTR = 8'hC0;
`else
  localparam logic [7:0] CTR = 8'h80;
`endif

  logic       wb_clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = 7'd0;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       m_cyc_o, m_stb_o, m_we_o;
  logic [2:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic [7:0] m_dat_i = 8'h00;
  logic       m_ack_i = 1'b0;
  logic       m_inta_i = 1'b0;

  i2c_seq_ctrl #(.PRESCALE(16'd99), .TIMEOUT(TO)) dut (
    .wb_clk_i(wb_clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_dev(req_dev),
    .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i), .m_inta_i(m_inta_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scenario handed from driver to core model
  int       txn_id = 0;
  int       cur_kind = 0;
  int       cur_k = 9;
  bit       cur_rw = 0;
  logic [7:0] rx_byte = 8'h00;

  // core model state
  logic [10:0] wlog[$];
  int       seen_id = -1;
  int       cmd_idx = 0;
  int       cd = 0;
  int       dly = 0;
  bit       armed = 0;
  bit       hang = 0;
  bit       held = 0;
  logic [12:0] held_v = '0;
  logic [7:0] sts = 8'h00;
  logic [7:0] noise;
  int       idle_bad = 0;
  int       hold_bad = 0;
  longint   cyc_n = 0;
  longint   t_hang = 0;
  longint   t_stop = 0;

  int acc_cnt = 0;
  int rsp_cnt = 0;

  always @(posedge wb_clk_i) begin
    cyc_n++;
    if (rst_i && req_valid && req_ready) acc_cnt++;
    if (rst_i && rsp_valid) rsp_cnt++;
  end

  always @(negedge wb_clk_i) begin
    if (cd > 0) cd--;
    if (m_ack_i) begin
      if (m_cyc_o || m_stb_o) idle_bad++;
      m_ack_i = 1'b0;
      dly = $urandom_range(0, 3);
      held = 0;
    end else if (m_cyc_o) begin
      if (held && {m_stb_o, m_we_o, m_adr_o, m_dat_o} !== held_v)
        hold_bad++;
      held_v = {m_stb_o, m_we_o, m_adr_o, m_dat_o};
      held = 1;
      if (dly > 0) dly--;
      else begin
        m_ack_i = 1'b1;
        held = 0;
        if (m_we_o) begin
          m_dat_i = 8'h00;
          wlog.push_back({m_adr_o, m_dat_o});
          if (m_adr_o == 3'd4) begin
            case (m_dat_o)
              8'h91, 8'h11, 8'h51, 8'h69: begin
                if (seen_id != txn_id) begin
                  seen_id = txn_id;
                  cmd_idx = 0;
                end
                hang = (cur_kind == 3 && cmd_idx == cur_k);
                if (cur_kind == 2 && cmd_idx == cur_k)
                  sts = ($urandom_range(0, 1) != 0) ? 8'hA1 : 8'h21;
                else if (cur_kind == 1 && cmd_idx == cur_k)
                  sts = 8'h81;
                else if (cur_rw && cmd_idx == 3)
                  sts = 8'h81;
                else
                  sts = 8'h01;
                if (hang) t_hang = cyc_n;
                cmd_idx++;
                armed = 1;
                cd = $urandom_range(0, 6);
              end
              8'h41: begin
                sts = 8'h01;
                hang = 0;
                armed = 1;
                cd = $urandom_range(0, 6);
              end
              default: begin
                armed = 0;
                if (m_dat_o == 8'h40) t_stop = cyc_n;
              end
            endcase
          end
        end else begin
          noise = 8'($urandom) & 8'h42;
          if (m_adr_o == 3'd3) m_dat_i = rx_byte;
          else if (m_adr_o == 3'd4)
            m_dat_i = (armed && !hang && cd == 0) ? (sts | noise) : noise;
          else m_dat_i = 8'h00;
        end
      end
    end else begin
      held = 0;
    end
    m_inta_i = armed && !hang && cd == 0;
  end

  // transaction-level reference: expected core writes, err and rdata
  logic [10:0] exp_q[$];

  task automatic build_exp(input bit rw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd,
                           input int kind, input int k,
                           output logic [1:0] e_err,
                           output logic [7:0] e_rd);
    int n;
    logic [7:0] cr;
    exp_q.delete();
    n = rw ? 4 : 3;
    e_rd = 8'h00;
    for (int j = 0; j < n; j++) begin
      if (j == 0) exp_q.push_back({3'd3, dev, 1'b0});
      if (j == 1) exp_q.push_back({3'd3, rg});
      if (j == 2) exp_q.push_back(rw ? {3'd3, dev, 1'b1} : {3'd3, wd});
      if (j == 0 || (j == 2 && rw)) cr = 8'h91;
      else if (j == 1) cr = 8'h11;
      else if (j == 2) cr = 8'h51;
      else cr = 8'h69;
      exp_q.push_back({3'd4, cr});
      if (j == k && kind == 3) begin
        exp_q.push_back({3'd4, 8'h40});
        e_err = 2'd3;
        return;
      end
      if (j == k && kind == 2) begin
        exp_q.push_back({3'd4, 8'h01});
        e_err = 2'd2;
        return;
      end
      if (j == k && kind == 1) begin
        exp_q.push_back({3'd4, 8'h41});
        exp_q.push_back({3'd4, 8'h01});
        e_err = 2'd1;
        return;
      end
    end
    exp_q.push_back({3'd4, 8'h01});
    e_err = 2'd0;
    if (rw) e_rd = rx_byte;
  endtask

  logic       p_rw;
  logic [6:0] p_dev;
  logic [7:0] p_reg, p_wd;
  bit         abort = 0;
  int         exp_acc = 0;
  int         exp_rsp = 0;

  task automatic new_req();
    p_rw  = 1'($urandom);
    p_dev = 7'($urandom);
    p_reg = 8'($urandom);
    p_wd  = 8'($urandom);
  endtask

  task automatic drive_req();
    req_rw    = p_rw;
    req_dev   = p_dev;
    req_reg   = p_reg;
    req_wdata = p_wd;
  endtask

  task automatic reset_init();
    int t;
    int base;
    logic [10:0] ie[3];
    rst_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("rst_out", {req_ready, rsp_valid, rsp_rdata, rsp_err, m_cyc_o,
                      m_stb_o, m_we_o, m_adr_o, m_dat_o}, 0);
    base = wlog.size();
    drive_req();
    req_valid = 1'b1;
    rst_i = 1'b1;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge wb_clk_i);
      t++;
    end
    check("init_rdy", req_ready, 1);
    check("init_len", wlog.size() - base, 3);
    ie[0] = {3'd0, 8'h63};
    ie[1] = {3'd1, 8'h00};
    ie[2] = {3'd2, CTR};
    for (int j = 0; j < 3 && base + j < wlog.size(); j++)
      check("init_wr", wlog[base + j], ie[j]);
  endtask

  task automatic run_txns(input int n);
    int t, kind, k, r, base;
    bit hold;
    logic [1:0] e_err;
    logic [7:0] e_rd;
    for (int i = 0; i < n && !abort; i++) begin
      t = 0;
      while (!(req_valid && req_ready) && t < 400) begin
        @(negedge wb_clk_i);
        t++;
      end
      check("accept", req_ready, 1);
      if (!req_ready) begin
        abort = 1;
        return;
      end
      r = $urandom_range(0, 7);
      kind = (r < 4) ? 0 : (r < 6) ? 1 : (r == 6) ? 2 : 3;
      k = (kind == 0) ? 9 :
          (kind == 1) ? $urandom_range(0, 2) :
          $urandom_range(0, p_rw ? 3 : 2);
      cur_rw = p_rw;
      cur_kind = kind;
      cur_k = k;
      rx_byte = 8'($urandom);
      txn_id++;
      base = wlog.size();
      build_exp(p_rw, p_dev, p_reg, p_wd, kind, k, e_err, e_rd);
      exp_acc++;
      hold = 1'($urandom);
      new_req();
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      check("rdy_drop", req_ready, 0);
      if (hold) drive_req();
      else begin
        req_valid = 1'b0;
        req_rw    = ~req_rw;
        req_dev   = ~req_dev;
        req_reg   = ~req_reg;
        req_wdata = ~req_wdata;
      end
      t = 0;
      while (!rsp_valid && t < 600) begin
        @(negedge wb_clk_i);
        t++;
      end
      check("rsp_valid", rsp_valid, 1);
      if (!rsp_valid) begin
        abort = 1;
        return;
      end
      exp_rsp++;
      check("rsp_err", rsp_err, e_err);
      check("rsp_rdata", rsp_rdata, e_rd);
      check("log_len", wlog.size() - base, exp_q.size());
      for (int j = 0; j < exp_q.size() && base + j < wlog.size(); j++)
        check("log_wr", wlog[base + j], exp_q[j]);
      if (kind == 3)
        check("to_window", 32'(t_stop - t_hang), 32'(t_stop - t_hang)
              >= 32'(TO) && 32'(t_stop - t_hang) <= 32'(TO) + 10 ?
              32'(t_stop - t_hang) : 32'(TO));
      check("wb_idle", idle_bad, 0);
      check("wb_hold", hold_bad, 0);
      if (i == n - 1) req_valid = 1'b0;
      else if (!hold) begin
        drive_req();
        req_valid = 1'b1;
      end
    end
  endtask

  task automatic midop_reset();
    int t;
    new_req();
    p_rw = 1'b0;
    drive_req();
    req_valid = 1'b1;
    cur_kind = 0;
    cur_k = 9;
    cur_rw = 1'b0;
    txn_id++;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge wb_clk_i);
      t++;
    end
    check("mid_accept", req_ready, 1);
    exp_acc++;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    req_valid = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    t = 0;
    while (!m_cyc_o && t < 50) begin
      @(negedge wb_clk_i);
      t++;
    end
    check("mid_busy", m_cyc_o, 1);
    rst_i = 1'b0;
    #1;
    check("rst_async", {m_cyc_o, m_stb_o, m_we_o, req_ready}, 0);
    new_req();
    reset_init();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    new_req();
    reset_init();
    run_txns(40);
    if (!abort) midop_reset();
    if (!abort) run_txns(12);
    repeat (4) @(negedge wb_clk_i);
    check("acc_cnt", acc_cnt, exp_acc);
    check("rsp_cnt", rsp_cnt, exp_rsp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_seq_ctrl.md
Name: i2c_seq_ctrl

Overview:
Wishbone master that sits directly upstream of the I2C master core and drives its 8-bit register interface.
- Converts single-beat host requests into complete I2C register transactions: "write register" (S, dev+W, reg, data, P) and "read register" (S, dev+W, reg, Sr, dev+R, data+NACK, P).
- Initialises the core after reset, sequences core commands, and detects NACK, arbitration loss and timeout.
- Returns one response per request.

Parameters:
PRESCALE, 16'd99, value written to prescale registers (adr 0 low byte, adr 1 high byte) during init.
TIMEOUT, 20'd1000000, maximum wb_clk_i cycles spent waiting for one core command to complete.

Ports:
wb_clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
req_valid  in  1  host request strobe
req_ready  out  1  sequencer idle and initialised; request accepted when req_valid & req_ready
req_rw  in  1  1 = read register, 0 = write register
req_dev  in  7  7-bit I2C device address
req_reg  in  8  device register address
req_wdata  in  8  write data (ignored for reads)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  8  read data (valid with rsp_valid on a successful read; 0 otherwise)
rsp_err  out  2  0 = OK, 1 = NACK, 2 = arbitration lost, 3 = timeout
m_cyc_o  out  1  Wishbone cycle
m_stb_o  out  1  Wishbone strobe
m_we_o  out  1  Wishbone write enable
m_adr_o  out  3  core register address
m_dat_o  out  8  write data to core
m_dat_i  in  8  read data from core
m_ack_i  in  1  core acknowledge
m_inta_i  in  1  core interrupt (used only with the optional feature)

Behaviour:
Reset values:
- All outputs are 0 in reset: req_ready, rsp_valid, rsp_rdata, rsp_err, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o.
- FSM resets to INIT.

Wishbone access rules:
- Single access only. m_cyc_o, m_stb_o, m_adr_o, m_we_o and m_dat_o are driven together and held until m_ack_i=1.
- In the cycle after m_ack_i, m_cyc_o and m_stb_o are 0. Minimum one idle cycle between accesses.
- Read data is captured from m_dat_i in the m_ack_i cycle.

Init, after reset release:
- Write adr0=PRESCALE[7:0], then adr1=PRESCALE[15:8], then adr2=8'h80 (core enable).
- Then enter IDLE with req_ready=1. No request is accepted before init completes.

Command encoding (core adr 4):
- Bits: STA=80, STO=40, RD=20, WR=10, ACK(NACK)=08, IACK=01.
- Every command write after the first also sets IACK, which clears the previous completion flag.

Write transaction sequence:
- txr(adr3)={dev,0}; cr=91; WAIT.
- txr=reg; cr=11; WAIT.
- txr=wdata; cr=51; WAIT.
- cr=01; respond.

Read transaction sequence:
- txr={dev,0}; cr=91; WAIT.
- txr=reg; cr=11; WAIT.
- txr={dev,1}; cr=91; WAIT.
- cr=69; WAIT.
- Read adr3 into rsp_rdata; cr=01; respond.

WAIT (polling):
- Repeatedly read sr at adr4 until sr[0]=1 (irq_flag).
- sr[1] (tip) is not used, because it lags the command write by one cycle.
- On exit, evaluate sr[5] (al) first, then sr[7] (rxack).
- rxack is checked after every write-phase WAIT. It is not checked after the final read-byte WAIT (master sends NACK itself).

Error handling:
- AL: cr=01 (no stop); respond with err=2.
- NACK: cr=41 (STO|IACK); WAIT; cr=01; respond with err=1. Remaining bytes are skipped.
- Timeout: wait counter reaches TIMEOUT; abandon any in-flight access; cr=40; respond with err=3. No further WAIT is performed.
- The wait counter is 20 bits, cleared at each WAIT entry, and saturates (no wrap).

FSM states:
- INIT0, INIT1, INIT2, IDLE, WR_TXR, WR_CR, POLL, EVAL, RD_RXR, STOP_CR, STOP_POLL, FINAL_IACK, RESP.
- A phase index (0-3) selects the next txr/cr values.

Response and handshake:
- RESP drives rsp_valid=1 for exactly one cycle, then returns to IDLE.
- req_ready=1 only in IDLE. It goes 0 in the cycle after acceptance.
- Request fields are latched at acceptance. Host changes to req_* after acceptance have no effect.

Reset mid-operation:
- Wishbone signals drop immediately.
- Init is repeated after reset release.

Optional Feature:
I2C_SEQ_IRQ_EN:
- Defined: init writes ctr=8'hC0 (enable + interrupt enable). WAIT performs no sr polling; it waits for m_inta_i=1, then performs one sr read for evaluation. The timeout counter still applies.
- Undefined: polling as described in Behaviour; m_inta_i is ignored.

Test Plan:
- Reset release with PRESCALE=99 -> Wishbone writes adr0=63, adr1=00, adr2=80 in order, then req_ready=1.
- Write request dev=50, reg=10, data=A5; slave ACKs all bytes -> txr writes A0,10,A5 with cr 91,11,51,01; rsp_valid pulse with err=0.
- Read request dev=50, reg=10; slave returns 3C -> cr sequence 91,11,91,69,01; txr A0,10,A1; rsp_rdata=3C, err=0.
- Device NACKs the address byte (sr reads 81) -> cr=41, then WAIT, then cr=01; err=1; no reg/data txr writes issued.
- Arbitration loss during reg byte (sr reads 21) -> cr=01 with no STO; err=2. Core never raises irq_flag -> after TIMEOUT cycles: cr=40, err=3, then req_ready=1.
- req_valid held high across back-to-back requests; stb held 3 cycles before ack -> exactly one acceptance per RESP; each Wishbone access is a single beat with an idle cycle before the next.
